div_result_buffer: RTL and testbench
====================================

Name: div_result_buffer

Overview:
- Sits directly downstream of the divider pipeline. Captures every result pulse (valid_output/final_output) into an in-order FIFO and drains it to a consumer over a valid/ready handshake.
- The divider pipeline cannot stall, so this block also does credit accounting for the upstream issuer. It counts operations issued into the divider but not yet returned, and gates further issue so that no result can ever find the FIFO full.

Parameters:
- DEPTH, 8, FIFO entries and total credit budget; power of two, >= 2.
- DATA_WIDTH, 17, result width; matches divider final_output.
- CW, $clog2(DEPTH+1), width of count and in-flight counters; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- issue_valid  input  1  tap of divider valid_input; one operation issued this cycle
- issue_mode  input  1  tap of divider mode; 0 = quotient, 1 = remainder
- div_valid  input  1  divider valid_output
- div_result  input  DATA_WIDTH  divider final_output, signed
- credit_ok  output  1  upstream may issue this cycle
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head this cycle
- out_data  output  DATA_WIDTH  head result, signed
- out_mode  output  1  mode tag of head result; only exists with DIV_RB_MODE_TAG_EN
- count  output  CW  entries currently stored
- err  output  1  sticky protocol error

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. Reset dominates every other input in the same cycle.
- Reset values: count=0, in_flight=0, read/write pointers=0, out_valid=0, out_data=0, out_mode=0, err=0. credit_ok=1 after reset, since it is derived from the registered counters.
- Reset mid-operation: all stored and in-flight accounting is discarded. Results arriving from the divider after reset count as unexpected and set err.
- Definitions: pop = out_valid & out_ready; full = (count == DEPTH).
- Push: div_valid writes div_result at the write pointer when !full, or when full and pop occurs in the same cycle.
- Push while full with no pop: the result is dropped and err is set.
- Pointers: width log2(DEPTH); wrap naturally modulo DEPTH.
- count: +1 on accepted push only; -1 on pop only; unchanged on simultaneous push and pop.
- Output path: out_valid = (count != 0). out_data/out_mode always show the head entry from storage, with no bypass. A result written at edge N is visible at out_valid/out_data after edge N.
- Empty FIFO: no pop is possible, and out_ready is ignored.
- in_flight counter (CW bits): +1 on issue_valid, -1 on div_valid, unchanged when both occur.
  - div_valid with in_flight=0: err is set and in_flight stays at 0.
  - in_flight saturates at DEPTH.
- credit_ok = (in_flight + count) < DEPTH. This is combinational from registers, with no look-ahead for same-cycle pops.
- issue_valid while credit_ok=0: the issue is still counted (subject to saturation) and err is set.
- Invariant under legal use: in_flight + count <= DEPTH, so a push never sees full.
- err is sticky until reset.
- Ordering: strictly in-order. The Nth div_valid corresponds to the Nth issue_valid.

Optional Feature:
- Macro: DIV_RB_MODE_TAG_EN.
- Defined:
  - A DEPTH-entry tag queue captures issue_mode on each issue_valid.
  - Each div_valid pops the tag queue and stores the tag beside the result in the main FIFO.
  - out_mode presents the tag of the head entry.
  - A div_valid with an empty tag queue stores tag 0 and sets err.
  - Reset clears the tag queue.
- Undefined: no tag queue, no out_mode port, and issue_mode is unused.

Test Plan (DEPTH=4):
- Reset, then issue 1 op with mode=0 and return div_result=17'sd25 three cycles later, out_ready=1 -> out_valid one cycle after div_valid, out_data=25, count returns to 0, credit_ok=1, err=0.
- 4 issues back-to-back, out_ready=0 -> credit_ok=0 after the 4th issue. Return results -3, 7, -128, 32767 -> count=4, credit_ok stays 0. Raise out_ready -> data drains in order -3, 7, -128, 32767.
- Full FIFO (4 stored) with a simultaneous div_valid (value 5) and pop (forced via an illegal extra issue) -> push accepted, count stays 4, 5 appears last; err=1 from the illegal issue.
- Full FIFO with out_ready=0 and div_valid carrying 9 -> 9 dropped, err=1, count=4, stored contents unchanged.
- div_valid with no prior issue after reset -> err=1, in_flight stays 0.
- DIV_RB_MODE_TAG_EN defined: issue modes 1,0,1 and results 2,10,3 -> out pairs (2,1),(10,0),(3,1). Assert reset mid-stream -> all outputs cleared next cycle, count=0.

Source files
------------

// File: rtl/div_result_buffer.sv
// Result buffer behind the divider: an in-order FIFO plus issue-credit accounting, so a result never finds the FIFO full.
// Latency: a result pushed at edge N is visible on out_valid/out_data after edge N; credit_ok is combinational from registers.
// Backpressure: out_ready stalls the drain only; the divider cannot stall, so issue is gated through credit_ok. Option macro: DIV_RB_MODE_TAG_EN.

// Generic storage FIFO. Callers pass already-qualified write/read enables.
module div_rb_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 17,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Head is read straight from storage; there is no write-through bypass.
  assign head_dat = mem[rd_ptr];

  // Storage, pointers and occupancy. Storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// Top level: result FIFO, in-flight counter, credit gate and sticky error.
module div_result_buffer #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 17,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic                         issue_mode,
  input  logic                         div_valid,
  input  logic signed [DATA_WIDTH-1:0] div_result,
  output logic                         credit_ok,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
`ifdef DIV_RB_MODE_TAG_EN
  output logic                         out_mode,
`endif
  output logic [CW-1:0]                count,
  output logic                         err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef DIV_RB_MODE_TAG_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif

  logic          full;
  logic          pop;
  logic          push_ok;
  logic          push_drop;
  logic          unexpected;
  logic          tag_err;
  logic [CW-1:0] in_flight;
  logic [CW:0]   credit_sum;
  logic [FW-1:0] fifo_wr_dat;
  logic [FW-1:0] fifo_head;

  assign out_valid  = (count != '0);
  assign full       = (count == DEPTH_C);
  assign pop        = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = div_valid & (~full | pop);
  assign push_drop  = div_valid & full & ~pop;
  assign unexpected = div_valid & (in_flight == '0);

  // Credits cover both results still inside the divider and results already stored.
  assign credit_sum = {1'b0, in_flight} + {1'b0, count};
  assign credit_ok  = (credit_sum < {1'b0, DEPTH_C});

`ifdef DIV_RB_MODE_TAG_EN
  logic          tag_head;
  logic [CW-1:0] tag_count;
  logic          tag_empty;
  logic          tag_full;
  logic          tag_rd;
  logic          tag_wr;
  logic          tag_val;

  assign tag_empty = (tag_count == '0);
  assign tag_full  = (tag_count == DEPTH_C);
  assign tag_rd    = div_valid & ~tag_empty;
  assign tag_wr    = issue_valid & (~tag_full | tag_rd);
  // A result with no matching issue gets tag 0 and is flagged.
  assign tag_val   = tag_empty ? 1'b0 : tag_head;
  assign tag_err   = div_valid & tag_empty;

  div_rb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (1),
    .CW    (CW)
  ) u_tag_q (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (tag_wr),
    .wr_dat   (issue_mode),
    .rd_en    (tag_rd),
    .head_dat (tag_head),
    .count    (tag_count)
  );

  assign fifo_wr_dat = {tag_val, div_result};
  assign out_mode    = fifo_head[DATA_WIDTH];
`else
  logic unused_issue_mode;

  assign unused_issue_mode = issue_mode;
  assign tag_err           = 1'b0;
  assign fifo_wr_dat       = div_result;
`endif

  assign out_data = fifo_head[DATA_WIDTH-1:0];

  div_rb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW),
    .CW    (CW)
  ) u_res_q (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (push_ok),
    .wr_dat   (fifo_wr_dat),
    .rd_en    (pop),
    .head_dat (fifo_head),
    .count    (count)
  );

  // Operations inside the divider: up on issue, down on return, clamped at 0 and DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight <= '0;
    end else begin
      case ({issue_valid, div_valid})
        2'b10: begin
          if (in_flight != DEPTH_C) begin
            in_flight <= in_flight + CNT_ONE;
          end
        end
        2'b01: begin
          if (in_flight != '0) begin
            in_flight <= in_flight - CNT_ONE;
          end
        end
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Sticky protocol error: dropped result, unexpected result, issue without credit, or missing tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (push_drop | unexpected | (issue_valid & ~credit_ok) | tag_err) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_result_buffer.sv
module tb_div_result_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 17;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic          issue_mode;
  logic          div_valid;
  logic [DW-1:0] div_result;
  logic          credit_ok;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          err;
`ifdef DIV_RB_MODE_TAG_EN
  logic          out_mode;
`endif

  always #5 clk = ~clk;

  div_result_buffer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_mode  (issue_mode),
    .div_valid   (div_valid),
    .div_result  (div_result),
    .credit_ok   (credit_ok),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
`ifdef DIV_RB_MODE_TAG_EN
    .out_mode    (out_mode),
`endif
    .count       (count),
    .err         (err)
  );

  typedef struct {
    logic          rst;
    logic          iv;
    logic          dv;
    logic [DW-1:0] dr;
    logic          rdy;
    logic          cok;
    logic          ov;
    logic          chk_od;
    logic [DW-1:0] od;
    logic [CW-1:0] cnt;
    logic          er;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic iv, input logic dv, input logic [DW-1:0] dr,
                     input logic rdy, input logic cok, input logic ov, input logic chk_od,
                     input logic [DW-1:0] od, input logic [CW-1:0] cnt, input logic er);
    vec_t t;
    t.rst = rst; t.iv = iv; t.dv = dv; t.dr = dr; t.rdy = rdy;
    t.cok = cok; t.ov = ov; t.chk_od = chk_od; t.od = od; t.cnt = cnt; t.er = er;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic rst, input logic iv, input logic im, input logic dv,
                     input logic [DW-1:0] dr, input logic rdy);
    reset = rst; issue_valid = iv; issue_mode = im;
    div_valid = dv; div_result = dr; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_mode = 1'b0;
    div_valid = 1'b0; div_result = '0; out_ready = 1'b0;

    //   rst iv dv dr             rdy | cok ov chk od             cnt er
    // Single op, result 25, drained immediately
    add(1, 0, 0, 17'd0,          0,   1,  0, 1,  17'd0,          3'd0, 0);
    add(0, 1, 0, 17'd0,          0,   1,  0, 0,  17'd0,          3'd0, 0);
    add(0, 0, 0, 17'd0,          0,   1,  0, 0,  17'd0,          3'd0, 0);
    add(0, 0, 0, 17'd0,          0,   1,  0, 0,  17'd0,          3'd0, 0);
    add(0, 0, 1, 17'd25,         1,   1,  1, 1,  17'd25,         3'd1, 0);
    add(0, 0, 0, 17'd0,          1,   1,  0, 0,  17'd0,          3'd0, 0);
    // Four issues exhaust credit, four results fill the FIFO, then drain in order
    add(0, 1, 0, 17'd0,          0,   1,  0, 0,  17'd0,          3'd0, 0);
    add(0, 1, 0, 17'd0,          0,   1,  0, 0,  17'd0,          3'd0, 0);
    add(0, 1, 0, 17'd0,          0,   1,  0, 0,  17'd0,          3'd0, 0);
    add(0, 1, 0, 17'd0,          0,   0,  0, 0,  17'd0,          3'd0, 0);
    add(0, 0, 1, -17'sd3,        0,   0,  1, 1,  -17'sd3,        3'd1, 0);
    add(0, 0, 1, 17'd7,          0,   0,  1, 1,  -17'sd3,        3'd2, 0);
    add(0, 0, 1, -17'sd128,      0,   0,  1, 1,  -17'sd3,        3'd3, 0);
    add(0, 0, 1, 17'd32767,      0,   0,  1, 1,  -17'sd3,        3'd4, 0);
    add(0, 0, 0, 17'd0,          1,   1,  1, 1,  17'd7,          3'd3, 0);
    add(0, 0, 0, 17'd0,          1,   1,  1, 1,  -17'sd128,      3'd2, 0);
    add(0, 0, 0, 17'd0,          1,   1,  1, 1,  17'd32767,      3'd1, 0);
    add(0, 0, 0, 17'd0,          1,   1,  0, 0,  17'd0,          3'd0, 0);
    add(0, 0, 0, 17'd0,          1,   1,  0, 0,  17'd0,          3'd0, 0);
    // Result with no issue: err set, stored, in_flight stays 0 (credit runs out after 3 issues)
    add(1, 0, 0, 17'd0,          0,   1,  0, 1,  17'd0,          3'd0, 0);
    add(0, 0, 1, 17'd99,         0,   1,  1, 1,  17'd99,         3'd1, 1);
    add(0, 1, 0, 17'd0,          0,   1,  1, 1,  17'd99,         3'd1, 1);
    add(0, 1, 0, 17'd0,          0,   1,  1, 1,  17'd99,         3'd1, 1);
    add(0, 1, 0, 17'd0,          0,   0,  1, 1,  17'd99,         3'd1, 1);
    // Full FIFO, no pop: result 9 dropped, contents unchanged
    add(1, 0, 0, 17'd0,          0,   1,  0, 1,  17'd0,          3'd0, 0);
    add(0, 1, 0, 17'd0,          0,   1,  0, 0,  17'd0,          3'd0, 0);
    add(0, 1, 0, 17'd0,          0,   1,  0, 0,  17'd0,          3'd0, 0);
    add(0, 1, 0, 17'd0,          0,   1,  0, 0,  17'd0,          3'd0, 0);
    add(0, 1, 0, 17'd0,          0,   0,  0, 0,  17'd0,          3'd0, 0);
    add(0, 0, 1, 17'd11,         0,   0,  1, 1,  17'd11,         3'd1, 0);
    add(0, 0, 1, 17'd22,         0,   0,  1, 1,  17'd11,         3'd2, 0);
    add(0, 0, 1, 17'd33,         0,   0,  1, 1,  17'd11,         3'd3, 0);
    add(0, 0, 1, 17'd44,         0,   0,  1, 1,  17'd11,         3'd4, 0);
    add(0, 0, 1, 17'd9,          0,   0,  1, 1,  17'd11,         3'd4, 1);
    add(0, 0, 0, 17'd0,          1,   1,  1, 1,  17'd22,         3'd3, 1);
    add(0, 0, 0, 17'd0,          1,   1,  1, 1,  17'd33,         3'd2, 1);
    add(0, 0, 0, 17'd0,          1,   1,  1, 1,  17'd44,         3'd1, 1);
    add(0, 0, 0, 17'd0,          1,   1,  0, 0,  17'd0,          3'd0, 1);
    // Full FIFO with push and pop together: 5 accepted, count stays 4, 5 drains last
    add(1, 0, 0, 17'd0,          0,   1,  0, 1,  17'd0,          3'd0, 0);
    add(0, 1, 0, 17'd0,          0,   1,  0, 0,  17'd0,          3'd0, 0);
    add(0, 1, 0, 17'd0,          0,   1,  0, 0,  17'd0,          3'd0, 0);
    add(0, 1, 0, 17'd0,          0,   1,  0, 0,  17'd0,          3'd0, 0);
    add(0, 1, 0, 17'd0,          0,   0,  0, 0,  17'd0,          3'd0, 0);
    add(0, 0, 1, 17'd1,          0,   0,  1, 1,  17'd1,          3'd1, 0);
    add(0, 0, 1, 17'd2,          0,   0,  1, 1,  17'd1,          3'd2, 0);
    add(0, 0, 1, 17'd3,          0,   0,  1, 1,  17'd1,          3'd3, 0);
    add(0, 0, 1, 17'd4,          0,   0,  1, 1,  17'd1,          3'd4, 0);
    add(0, 1, 0, 17'd0,          0,   0,  1, 1,  17'd1,          3'd4, 1);
    add(0, 0, 1, 17'd5,          1,   0,  1, 1,  17'd2,          3'd4, 1);
    add(0, 0, 0, 17'd0,          1,   1,  1, 1,  17'd3,          3'd3, 1);
    add(0, 0, 0, 17'd0,          1,   1,  1, 1,  17'd4,          3'd2, 1);
    add(0, 0, 0, 17'd0,          1,   1,  1, 1,  17'd5,          3'd1, 1);
    add(0, 0, 0, 17'd0,          1,   1,  0, 0,  17'd0,          3'd0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].iv, 1'b0, vecs[i].dv, vecs[i].dr, vecs[i].rdy);
      check($sformatf("v%0d credit_ok", i), 32'(credit_ok), 32'(vecs[i].cok));
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].er));
      if (vecs[i].chk_od) begin
        check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].od));
      end
    end

    // in_flight saturation: 6 issues clamp at 4, so 3 returns leave 1 in flight
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 17'd0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 17'd0, 1'b0);
    check("sat credit_ok after 6 issues", 32'(credit_ok), 32'd0);
    check("sat err after over-issue", 32'(err), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 17'd1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 17'd2, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 17'd3, 1'b1);
    check("sat count", 32'(count), 32'd1);
    check("sat out_data", 32'(out_data), 32'd3);
    check("sat credit_ok after 3 returns", 32'(credit_ok), 32'd1);

`ifdef DIV_RB_MODE_TAG_EN
    // Mode tags follow their results; reset mid-stream clears everything
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 17'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 17'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 17'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 17'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 17'd2, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 17'd10, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 17'd3, 1'b0);
    check("tag count", 32'(count), 32'd3);
    check("tag pair1 data", 32'(out_data), 32'd2);
    check("tag pair1 mode", 32'(out_mode), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 17'd0, 1'b1);
    check("tag pair2 data", 32'(out_data), 32'd10);
    check("tag pair2 mode", 32'(out_mode), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 17'd0, 1'b1);
    check("tag pair3 data", 32'(out_data), 32'd3);
    check("tag pair3 mode", 32'(out_mode), 32'd1);
    check("tag err", 32'(err), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 17'd0, 1'b0);
    check("tag rst out_valid", 32'(out_valid), 32'd0);
    check("tag rst out_data", 32'(out_data), 32'd0);
    check("tag rst out_mode", 32'(out_mode), 32'd0);
    check("tag rst count", 32'(count), 32'd0);
    check("tag rst credit_ok", 32'(credit_ok), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
